// File: rtl/bloco_inferencia.sv
// Fuzzy rule inference for a 3x3 rule base of interval (upper/lower) membership grades.
// Each captured input pair is min-combined, streamed once per rule, and max-aggregated per consequent.
module bloco_inferencia #(
    parameter logic [1:0] RC0 = 2'd0,
    parameter logic [1:0] RC1 = 2'd0,
    parameter logic [1:0] RC2 = 2'd1,
    parameter logic [1:0] RC3 = 2'd0,
    parameter logic [1:0] RC4 = 2'd1,
    parameter logic [1:0] RC5 = 2'd2,
    parameter logic [1:0] RC6 = 2'd1,
    parameter logic [1:0] RC7 = 2'd2,
    parameter logic [1:0] RC8 = 2'd2
) (
    input  logic       clk,
    input  logic       RESET,
    input  logic       EN_SCLK,
    input  logic       start,
    input  logic [7:0] FOU_01_UP,
    input  logic [7:0] FOU_02_UP,
    input  logic [7:0] FOU_03_UP,
    input  logic [7:0] FOU_04_UP,
    input  logic [7:0] FOU_05_UP,
    input  logic [7:0] FOU_06_UP,
    input  logic [7:0] FOU_01_LOW,
    input  logic [7:0] FOU_02_LOW,
    input  logic [7:0] FOU_03_LOW,
    input  logic [7:0] FOU_04_LOW,
    input  logic [7:0] FOU_05_LOW,
    input  logic [7:0] FOU_06_LOW,
    input  logic [5:0] Ativo_UP,
    output logic       busy,
    output logic       rule_valid,
    output logic [3:0] rule_idx,
    output logic [7:0] F_UP,
    output logic [7:0] F_LOW,
    output logic [7:0] AGG_UP_0,
    output logic [7:0] AGG_UP_1,
    output logic [7:0] AGG_UP_2,
    output logic [7:0] AGG_LOW_0,
    output logic [7:0] AGG_LOW_1,
    output logic [7:0] AGG_LOW_2,
    output logic       done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EVAL = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [3:0] LAST_RULE = 4'd8;

    function automatic logic [1:0] rc_of(input logic [3:0] r);
        case (r)
            4'd0:    rc_of = RC0;
            4'd1:    rc_of = RC1;
            4'd2:    rc_of = RC2;
            4'd3:    rc_of = RC3;
            4'd4:    rc_of = RC4;
            4'd5:    rc_of = RC5;
            4'd6:    rc_of = RC6;
            4'd7:    rc_of = RC7;
            4'd8:    rc_of = RC8;
            default: rc_of = 2'd3;
        endcase
    endfunction

    // Input-1 set of rule r (r / 3).
    function automatic logic [2:0] set_i(input logic [3:0] r);
        case (r)
            4'd0, 4'd1, 4'd2: set_i = 3'd0;
            4'd3, 4'd4, 4'd5: set_i = 3'd1;
            4'd6, 4'd7, 4'd8: set_i = 3'd2;
            default:          set_i = 3'd0;
        endcase
    endfunction

    // Input-2 set of rule r (r mod 3).
    function automatic logic [2:0] set_j(input logic [3:0] r);
        case (r)
            4'd0, 4'd3, 4'd6: set_j = 3'd0;
            4'd1, 4'd4, 4'd7: set_j = 3'd1;
            4'd2, 4'd5, 4'd8: set_j = 3'd2;
            default:          set_j = 3'd0;
        endcase
    endfunction

    function automatic logic [7:0] min8(input logic [7:0] a, input logic [7:0] b);
        min8 = (a < b) ? a : b;
    endfunction

    function automatic logic [7:0] max8(input logic [7:0] a, input logic [7:0] b);
        max8 = (a > b) ? a : b;
    endfunction

    logic [7:0] fou_up_s  [0:5];
    logic [7:0] fou_low_s [0:5];

    assign fou_up_s[0]  = FOU_01_UP;
    assign fou_up_s[1]  = FOU_02_UP;
    assign fou_up_s[2]  = FOU_03_UP;
    assign fou_up_s[3]  = FOU_04_UP;
    assign fou_up_s[4]  = FOU_05_UP;
    assign fou_up_s[5]  = FOU_06_UP;
    assign fou_low_s[0] = FOU_01_LOW;
    assign fou_low_s[1] = FOU_02_LOW;
    assign fou_low_s[2] = FOU_03_LOW;
    assign fou_low_s[3] = FOU_04_LOW;
    assign fou_low_s[4] = FOU_05_LOW;
    assign fou_low_s[5] = FOU_06_LOW;

    logic [1:0] state_q,      state_d;
    logic [3:0] r_q,          r_d;
    logic       busy_q,       busy_d;
    logic       rule_valid_q, rule_valid_d;
    logic       done_q,       done_d;
    logic [3:0] rule_idx_q,   rule_idx_d;
    logic [7:0] f_up_q,       f_up_d;
    logic [7:0] f_low_q,      f_low_d;
    logic [5:0] cap_act_q,    cap_act_d;
    logic [7:0] cap_up_q  [0:5];
    logic [7:0] cap_up_d  [0:5];
    logic [7:0] cap_low_q [0:5];
    logic [7:0] cap_low_d [0:5];
    logic [7:0] agg_up_q  [0:2];
    logic [7:0] agg_up_d  [0:2];
    logic [7:0] agg_low_q [0:2];
    logic [7:0] agg_low_d [0:2];

    logic [2:0] i_s, j_s;
    logic [1:0] c_s;
    logic       act_s;
    logic [7:0] fu_s, fl_s;

    // Firing strength of the rule selected by the counter, from the frozen capture.
    always_comb begin
        i_s   = set_i(r_q);
        j_s   = set_j(r_q);
        c_s   = rc_of(r_q);
        act_s = cap_act_q[3'd5 - i_s] & cap_act_q[3'd2 - j_s];
        if (act_s) begin
            fu_s = min8(cap_up_q[i_s],  cap_up_q[3'd3 + j_s]);
            fl_s = min8(cap_low_q[i_s], cap_low_q[3'd3 + j_s]);
        end else begin
            fu_s = 8'd0;
            fl_s = 8'd0;
        end
    end

    // Next-state logic: capture on accepted start, stream and aggregate one rule per edge.
    always_comb begin
        state_d      = state_q;
        r_d          = r_q;
        rule_valid_d = 1'b0;
        done_d       = 1'b0;
        rule_idx_d   = rule_idx_q;
        f_up_d       = f_up_q;
        f_low_d      = f_low_q;
        cap_act_d    = cap_act_q;
        cap_up_d     = cap_up_q;
        cap_low_d    = cap_low_q;
        agg_up_d     = agg_up_q;
        agg_low_d    = agg_low_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    cap_act_d = Ativo_UP;
                    cap_up_d  = fou_up_s;
                    cap_low_d = fou_low_s;
                    for (int c = 0; c < 3; c++) begin
                        agg_up_d[c]  = 8'd0;
                        agg_low_d[c] = 8'd0;
                    end
                    r_d     = 4'd0;
                    state_d = S_EVAL;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_EVAL: begin
                rule_valid_d = 1'b1;
                rule_idx_d   = r_q;
                f_up_d       = fu_s;
                f_low_d      = fl_s;
                if (c_s != 2'd3) begin
                    agg_up_d[c_s]  = max8(agg_up_q[c_s],  fu_s);
                    agg_low_d[c_s] = max8(agg_low_q[c_s], fl_s);
                end else begin
                    agg_up_d  = agg_up_q;
                    agg_low_d = agg_low_q;
                end
                if (r_q == LAST_RULE) begin
                    done_d  = 1'b1;
                    r_d     = 4'd0;
                    state_d = S_DONE;
                end else begin
                    r_d = r_q + 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                r_d     = 4'd0;
            end
        endcase
        busy_d = (state_d == S_EVAL);
    end

    // State and output registers; EN_SCLK low freezes everything.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state_q      <= S_IDLE;
            r_q          <= 4'd0;
            busy_q       <= 1'b0;
            rule_valid_q <= 1'b0;
            done_q       <= 1'b0;
            rule_idx_q   <= 4'd0;
            f_up_q       <= 8'd0;
            f_low_q      <= 8'd0;
            cap_act_q    <= 6'd0;
            for (int k = 0; k < 6; k++) begin
                cap_up_q[k]  <= 8'd0;
                cap_low_q[k] <= 8'd0;
            end
            for (int c = 0; c < 3; c++) begin
                agg_up_q[c]  <= 8'd0;
                agg_low_q[c] <= 8'd0;
            end
        end else if (EN_SCLK) begin
            state_q      <= state_d;
            r_q          <= r_d;
            busy_q       <= busy_d;
            rule_valid_q <= rule_valid_d;
            done_q       <= done_d;
            rule_idx_q   <= rule_idx_d;
            f_up_q       <= f_up_d;
            f_low_q      <= f_low_d;
            cap_act_q    <= cap_act_d;
            cap_up_q     <= cap_up_d;
            cap_low_q    <= cap_low_d;
            agg_up_q     <= agg_up_d;
            agg_low_q    <= agg_low_d;
        end
    end

    assign busy       = busy_q;
    assign rule_valid = rule_valid_q;
    assign done       = done_q;
    assign rule_idx   = rule_idx_q;
    assign F_UP       = f_up_q;
    assign F_LOW      = f_low_q;
    assign AGG_UP_0   = agg_up_q[0];
    assign AGG_UP_1   = agg_up_q[1];
    assign AGG_UP_2   = agg_up_q[2];
    assign AGG_LOW_0  = agg_low_q[0];
    assign AGG_LOW_1  = agg_low_q[1];
    assign AGG_LOW_2  = agg_low_q[2];

endmodule

// File: tb/tb_bloco_inferencia.sv
// Randomized bench for bloco_inferencia: a rule-table model predicts the rule stream and aggregates.
module tb_bloco_inferencia;

    logic       clk = 1'b0;
    logic       RESET;
    logic       EN_SCLK;
    logic       start;
    logic [7:0] up_v  [6];
    logic [7:0] low_v [6];
    logic [5:0] act_v;
    logic       busy, rule_valid, done;
    logic [3:0] rule_idx;
    logic [7:0] F_UP, F_LOW;
    logic [7:0] AGG_UP_0, AGG_UP_1, AGG_UP_2, AGG_LOW_0, AGG_LOW_1, AGG_LOW_2;

    int n_vec = 0;
    int n_err = 0;
    int rc [9] = '{0, 0, 1, 0, 1, 2, 1, 2, 2};
    int exp_fu [9];
    int exp_fl [9];
    int exp_au [3];
    int exp_al [3];

    bloco_inferencia dut (
        .clk(clk), .RESET(RESET), .EN_SCLK(EN_SCLK), .start(start),
        .FOU_01_UP(up_v[0]), .FOU_02_UP(up_v[1]), .FOU_03_UP(up_v[2]),
        .FOU_04_UP(up_v[3]), .FOU_05_UP(up_v[4]), .FOU_06_UP(up_v[5]),
        .FOU_01_LOW(low_v[0]), .FOU_02_LOW(low_v[1]), .FOU_03_LOW(low_v[2]),
        .FOU_04_LOW(low_v[3]), .FOU_05_LOW(low_v[4]), .FOU_06_LOW(low_v[5]),
        .Ativo_UP(act_v), .busy(busy), .rule_valid(rule_valid), .rule_idx(rule_idx),
        .F_UP(F_UP), .F_LOW(F_LOW),
        .AGG_UP_0(AGG_UP_0), .AGG_UP_1(AGG_UP_1), .AGG_UP_2(AGG_UP_2),
        .AGG_LOW_0(AGG_LOW_0), .AGG_LOW_1(AGG_LOW_1), .AGG_LOW_2(AGG_LOW_2),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected rule stream and aggregates from the current input snapshot.
    function automatic void model();
        for (int c = 0; c < 3; c++) begin
            exp_au[c] = 0;
            exp_al[c] = 0;
        end
        for (int r = 0; r < 9; r++) begin
            int i = r / 3;
            int j = r % 3;
            bit a = act_v[5 - i] && act_v[2 - j];
            exp_fu[r] = a ? ((up_v[i]  < up_v[3 + j])  ? up_v[i]  : up_v[3 + j])  : 0;
            exp_fl[r] = a ? ((low_v[i] < low_v[3 + j]) ? low_v[i] : low_v[3 + j]) : 0;
            if (rc[r] != 3) begin
                if (exp_fu[r] > exp_au[rc[r]]) exp_au[rc[r]] = exp_fu[r];
                if (exp_fl[r] > exp_al[rc[r]]) exp_al[rc[r]] = exp_fl[r];
            end
        end
    endfunction

    task automatic scramble();
        for (int k = 0; k < 6; k++) begin
            up_v[k]  = 8'($urandom_range(0, 255));
            low_v[k] = 8'($urandom_range(0, 255));
        end
        act_v = 6'($urandom);
    endtask

    task automatic check_aggs(input int u0, u1, u2, l0, l1, l2);
        check_val("agg_up_0",  {24'd0, AGG_UP_0},  u0);
        check_val("agg_up_1",  {24'd0, AGG_UP_1},  u1);
        check_val("agg_up_2",  {24'd0, AGG_UP_2},  u2);
        check_val("agg_low_0", {24'd0, AGG_LOW_0}, l0);
        check_val("agg_low_1", {24'd0, AGG_LOW_1}, l1);
        check_val("agg_low_2", {24'd0, AGG_LOW_2}, l2);
    endtask

    task automatic check_all_zero();
        check_val("rst_busy",  {31'd0, busy}, 0);
        check_val("rst_valid", {31'd0, rule_valid}, 0);
        check_val("rst_done",  {31'd0, done}, 0);
        check_val("rst_idx",   {28'd0, rule_idx}, 0);
        check_val("rst_f_up",  {24'd0, F_UP}, 0);
        check_val("rst_f_low", {24'd0, F_LOW}, 0);
        check_aggs(0, 0, 0, 0, 0, 0);
    endtask

    // mode 0: EN always 1; 1: alternate 0/1; 2: random stalls. abort_at >= 0 resets after that rule.
    task automatic do_run(input int mode, input bit hold, input int abort_at);
        int nd;
        model();
        start   = 1'b1;
        EN_SCLK = 1'b1;
        tick();
        check_val("acc_busy",  {31'd0, busy}, 1);
        check_val("acc_valid", {31'd0, rule_valid}, 0);
        check_val("acc_done",  {31'd0, done}, 0);
        check_aggs(0, 0, 0, 0, 0, 0);
        if (!hold) start = 1'b0;
        for (int k = 0; k < 9; k++) begin
            nd = (mode == 0) ? 0 : (mode == 1) ? 1 : int'($urandom_range(0, 2));
            repeat (nd) begin
                scramble();
                EN_SCLK = 1'b0;
                tick();
                check_val("stall_valid", {31'd0, rule_valid}, (k > 0) ? 1 : 0);
                check_val("stall_done",  {31'd0, done}, 0);
                if (k > 0) begin
                    check_val("stall_idx",  {28'd0, rule_idx}, k - 1);
                    check_val("stall_f_up", {24'd0, F_UP}, exp_fu[k - 1]);
                end
            end
            scramble();
            EN_SCLK = 1'b1;
            tick();
            check_val("rule_valid", {31'd0, rule_valid}, 1);
            check_val("rule_idx",   {28'd0, rule_idx}, k);
            check_val("f_up",       {24'd0, F_UP}, exp_fu[k]);
            check_val("f_low",      {24'd0, F_LOW}, exp_fl[k]);
            check_val("done",       {31'd0, done}, (k == 8) ? 1 : 0);
            check_val("busy",       {31'd0, busy}, (k == 8) ? 0 : 1);
            if (k == abort_at) begin
                RESET = 1'b1;
                #1;
                check_all_zero();
                tick();
                RESET = 1'b0;
                tick();
                check_val("post_rst_busy", {31'd0, busy}, 0);
                check_val("post_rst_done", {31'd0, done}, 0);
                return;
            end
        end
        check_aggs(exp_au[0], exp_au[1], exp_au[2], exp_al[0], exp_al[1], exp_al[2]);
    endtask

    initial begin
        RESET   = 1'b1;
        EN_SCLK = 1'b0;
        start   = 1'b0;
        for (int k = 0; k < 6; k++) begin
            up_v[k]  = 8'd0;
            low_v[k] = 8'd0;
        end
        act_v = 6'd0;
        #2;
        check_all_zero();
        tick();
        tick();
        RESET   = 1'b0;
        EN_SCLK = 1'b1;
        tick();

        // Rule 0 = min(200,100) / min(150,120)
        scramble();
        act_v = 6'b111111;
        up_v[0] = 8'd200; up_v[3] = 8'd100; low_v[0] = 8'd150; low_v[3] = 8'd120;
        do_run(0, 1'b0, -1);
        check_val("r030_f_up0", exp_fu[0], 100);
        check_val("r030_f_low0", exp_fl[0], 120);

        // Only set 0 of each input active
        for (int k = 0; k < 6; k++) begin
            up_v[k]  = 8'd0;
            low_v[k] = 8'd0;
        end
        act_v = 6'b100100;
        up_v[0] = 8'd255; low_v[0] = 8'd200; up_v[3] = 8'd255; low_v[3] = 8'd200;
        do_run(0, 1'b0, -1);
        check_aggs(255, 0, 0, 200, 0, 0);

        // Uniform grades, continuous and half-rate enable
        for (int m = 0; m < 2; m++) begin
            act_v = 6'b111111;
            for (int k = 0; k < 6; k++) begin
                up_v[k]  = 8'd80;
                low_v[k] = 8'd40;
            end
            do_run(m, 1'b0, -1);
            check_aggs(80, 80, 80, 40, 40, 40);
        end

        start   = 1'b0;
        EN_SCLK = 1'b1;
        tick();
        check_val("idle_busy", {31'd0, busy}, 0);
        check_val("idle_done", {31'd0, done}, 0);
        check_val("idle_valid", {31'd0, rule_valid}, 0);
        check_aggs(80, 80, 80, 40, 40, 40);

        scramble();
        do_run(2, 1'b0, 4);
        scramble();
        do_run(0, 1'b0, -1);

        // start held: re-accepted straight out of DONE
        scramble();
        do_run(0, 1'b1, -1);
        scramble();
        do_run(1, 1'b1, -1);

        repeat (20) begin
            scramble();
            do_run(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
